// File: rtl/four_bit_rca_pkg.sv
// four_bit_rca_pkg: shared width constant and operand type for the ripple-carry adder.
package four_bit_rca_pkg;
    localparam int RCA_WIDTH = 4;
    typedef logic [RCA_WIDTH-1:0] operand_t;
endpackage

// File: rtl/four_bit_rca_if.sv
// four_bit_rca_if: operand/result bundle for four_bit_rca.
// master drives A, B, Cin, in_valid; slave (the adder) drives S, Cout, S_q, Cout_q, out_valid.
// With FOUR_BIT_RCA_OVF_EN defined the bundle also carries Ovf and Ovf_q.
interface four_bit_rca_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             in_valid;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic [WIDTH-1:0] S_q;
    logic             Cout_q;
    logic             out_valid;
`ifdef FOUR_BIT_RCA_OVF_EN
    logic             Ovf;
    logic             Ovf_q;
    modport master (output A, B, Cin, in_valid, input S, Cout, S_q, Cout_q, out_valid, Ovf, Ovf_q);
    modport slave  (input A, B, Cin, in_valid, output S, Cout, S_q, Cout_q, out_valid, Ovf, Ovf_q);
`else
    modport master (output A, B, Cin, in_valid, input S, Cout, S_q, Cout_q, out_valid);
    modport slave  (input A, B, Cin, in_valid, output S, Cout, S_q, Cout_q, out_valid);
`endif
endinterface

// File: rtl/four_bit_rca_full_adder.sv
// full_adder: one-bit full adder cell; a, b, ci in -> s, co out.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

// File: rtl/four_bit_rca.sv
// four_bit_rca: WIDTH-bit ripple-carry adder with a combinational sum and a registered copy.
// Ports: clk, rst (sync active-high); bus (four_bit_rca_if.slave) carries A, B, Cin, in_valid
// in and S, Cout (combinational), S_q, Cout_q, out_valid (registered) out.
// Define FOUR_BIT_RCA_OVF_EN to add signed overflow outputs Ovf and Ovf_q.
module four_bit_rca
    import four_bit_rca_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH
) (
    input logic           clk,
    input logic           rst,
    four_bit_rca_if.slave bus
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    assign c[0] = bus.Cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a  (bus.A[i]),
            .b  (bus.B[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end
    assign bus.S    = s;
    assign bus.Cout = c[WIDTH];
`ifdef FOUR_BIT_RCA_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign bus.Ovf = c[WIDTH] ^ c[WIDTH-1];
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.S_q       <= '0;
            bus.Cout_q    <= 1'b0;
            bus.out_valid <= 1'b0;
`ifdef FOUR_BIT_RCA_OVF_EN
            bus.Ovf_q     <= 1'b0;
`endif
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.S_q    <= s;
                bus.Cout_q <= c[WIDTH];
`ifdef FOUR_BIT_RCA_OVF_EN
                bus.Ovf_q  <= c[WIDTH] ^ c[WIDTH-1];
`endif
            end
        end
    end
endmodule

// File: tb/tb_four_bit_rca.sv
// tb_four_bit_rca: directed self-checking bench for four_bit_rca.
module tb_four_bit_rca;
    import four_bit_rca_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    four_bit_rca_if #(.WIDTH(RCA_WIDTH)) bus ();
    four_bit_rca #(.WIDTH(RCA_WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic drive(input operand_t a, input operand_t b, input logic cin, input logic v);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.Cin = cin;
        bus.in_valid = v;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        edge_step();
        n_chk++;
        if ({bus.S_q, bus.Cout_q, bus.out_valid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_regs got S_q=%b Cout_q=%b out_valid=%b exp 0000 0 0", bus.S_q, bus.Cout_q, bus.out_valid);
        end
`ifdef FOUR_BIT_RCA_OVF_EN
        n_chk++;
        if (bus.Ovf_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf_q got %b exp 0", bus.Ovf_q);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        drive(4'b1010, 4'b0011, 1'b0, 1'b1);
        n_chk++;
        if ({bus.Cout, bus.S} !== 5'b0_1101) begin
            n_fail++;
            $display("FAIL basic_comb got Cout=%b S=%b exp 0 1101", bus.Cout, bus.S);
        end
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pre_valid got %b exp 0", bus.out_valid);
        end
        edge_step();
        n_chk++;
        if ({bus.S_q, bus.Cout_q, bus.out_valid} !== 6'b1101_0_1) begin
            n_fail++;
            $display("FAIL basic_reg got S_q=%b Cout_q=%b out_valid=%b exp 1101 0 1", bus.S_q, bus.Cout_q, bus.out_valid);
        end
    endtask

    task automatic test_hold();
        drive(4'b0110, 4'b0110, 1'b1, 1'b0);
        n_chk++;
        if ({bus.Cout, bus.S} !== 5'b0_1101) begin
            n_fail++;
            $display("FAIL hold_comb got Cout=%b S=%b exp 0 1101", bus.Cout, bus.S);
        end
        edge_step();
        n_chk++;
        if ({bus.S_q, bus.Cout_q, bus.out_valid} !== 6'b1101_0_0) begin
            n_fail++;
            $display("FAIL hold_reg got S_q=%b Cout_q=%b out_valid=%b exp 1101 0 0", bus.S_q, bus.Cout_q, bus.out_valid);
        end
    endtask

    task automatic test_signed();
        drive(4'b0001, 4'b1100, 1'b0, 1'b0);
        n_chk++;
        if ({bus.Cout, bus.S} !== 5'b0_1101 || $signed(bus.S) !== -4'sd3) begin
            n_fail++;
            $display("FAIL signed_neg3 got Cout=%b S=%b exp 0 1101", bus.Cout, bus.S);
        end
`ifdef FOUR_BIT_RCA_OVF_EN
        n_chk++;
        if (bus.Ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL signed_ovf got %b exp 0", bus.Ovf);
        end
`endif
    endtask

    task automatic test_carry();
        drive(4'b1111, 4'b0001, 1'b0, 1'b1);
        n_chk++;
        if ({bus.Cout, bus.S} !== 5'b1_0000) begin
            n_fail++;
            $display("FAIL carry_wrap got Cout=%b S=%b exp 1 0000", bus.Cout, bus.S);
        end
        edge_step();
        n_chk++;
        if ({bus.S_q, bus.Cout_q, bus.out_valid} !== 6'b0000_1_1) begin
            n_fail++;
            $display("FAIL carry_wrap_reg got S_q=%b Cout_q=%b out_valid=%b exp 0000 1 1", bus.S_q, bus.Cout_q, bus.out_valid);
        end
        drive(4'b1111, 4'b1111, 1'b1, 1'b1);
        n_chk++;
        if ({bus.Cout, bus.S} !== 5'b1_1111) begin
            n_fail++;
            $display("FAIL carry_max got Cout=%b S=%b exp 1 1111", bus.Cout, bus.S);
        end
        edge_step();
        n_chk++;
        if ({bus.S_q, bus.Cout_q, bus.out_valid} !== 6'b1111_1_1) begin
            n_fail++;
            $display("FAIL carry_max_reg got S_q=%b Cout_q=%b out_valid=%b exp 1111 1 1", bus.S_q, bus.Cout_q, bus.out_valid);
        end
    endtask

    task automatic test_overflow();
        drive(4'b0111, 4'b0001, 1'b0, 1'b1);
        n_chk++;
        if ({bus.Cout, bus.S} !== 5'b0_1000) begin
            n_fail++;
            $display("FAIL ovf_pos got Cout=%b S=%b exp 0 1000", bus.Cout, bus.S);
        end
`ifdef FOUR_BIT_RCA_OVF_EN
        n_chk++;
        if (bus.Ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_pos_flag got %b exp 1", bus.Ovf);
        end
        edge_step();
        n_chk++;
        if (bus.Ovf_q !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_pos_q got %b exp 1", bus.Ovf_q);
        end
`endif
        drive(4'b1000, 4'b1000, 1'b0, 1'b0);
        n_chk++;
        if ({bus.Cout, bus.S} !== 5'b1_0000) begin
            n_fail++;
            $display("FAIL ovf_neg got Cout=%b S=%b exp 1 0000", bus.Cout, bus.S);
        end
`ifdef FOUR_BIT_RCA_OVF_EN
        n_chk++;
        if (bus.Ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_neg_flag got %b exp 1", bus.Ovf);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        drive(4'b0011, 4'b0100, 1'b0, 1'b1);
        edge_step();
        n_chk++;
        if ({bus.S_q, bus.out_valid} !== 5'b0111_1) begin
            n_fail++;
            $display("FAIL mid_pre got S_q=%b out_valid=%b exp 0111 1", bus.S_q, bus.out_valid);
        end
        rst = 1'b1;
        drive(4'b0101, 4'b0010, 1'b1, 1'b1);
        n_chk++;
        if ({bus.Cout, bus.S} !== 5'b0_1000) begin
            n_fail++;
            $display("FAIL mid_comb got Cout=%b S=%b exp 0 1000", bus.Cout, bus.S);
        end
        edge_step();
        n_chk++;
        if ({bus.S_q, bus.Cout_q, bus.out_valid} !== 6'b0) begin
            n_fail++;
            $display("FAIL mid_reg got S_q=%b Cout_q=%b out_valid=%b exp 0000 0 0", bus.S_q, bus.Cout_q, bus.out_valid);
        end
        n_chk++;
        if ({bus.Cout, bus.S} !== 5'b0_1000) begin
            n_fail++;
            $display("FAIL mid_comb_after got Cout=%b S=%b exp 0 1000", bus.Cout, bus.S);
        end
        rst = 1'b0;
        drive(4'b1001, 4'b0100, 1'b0, 1'b1);
        edge_step();
        n_chk++;
        if ({bus.S_q, bus.Cout_q, bus.out_valid} !== 6'b1101_0_1) begin
            n_fail++;
            $display("FAIL first_after_rst got S_q=%b Cout_q=%b out_valid=%b exp 1101 0 1", bus.S_q, bus.Cout_q, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive(4'b0010, 4'b0011, 1'b0, 1'b1);
        edge_step();
        n_chk++;
        if ({bus.S_q, bus.out_valid} !== 5'b0101_1) begin
            n_fail++;
            $display("FAIL b2b_first got S_q=%b out_valid=%b exp 0101 1", bus.S_q, bus.out_valid);
        end
        drive(4'b1100, 4'b0101, 1'b1, 1'b1);
        edge_step();
        n_chk++;
        if ({bus.S_q, bus.Cout_q, bus.out_valid} !== 6'b0010_1_1) begin
            n_fail++;
            $display("FAIL b2b_second got S_q=%b Cout_q=%b out_valid=%b exp 0010 1 1", bus.S_q, bus.Cout_q, bus.out_valid);
        end
    endtask

    task automatic test_exhaustive();
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    logic [4:0] exp_sum;
                    exp_sum = 5'(a + b + ci);
                    bus.A = 4'(a);
                    bus.B = 4'(b);
                    bus.Cin = 1'(ci);
                    #1;
                    n_chk++;
                    if ({bus.Cout, bus.S} !== exp_sum) begin
                        n_fail++;
                        $display("FAIL exh a=%0d b=%0d cin=%0d got %b exp %b", a, b, ci, {bus.Cout, bus.S}, exp_sum);
                    end
`ifdef FOUR_BIT_RCA_OVF_EN
                    begin
                        int  ss;
                        logic exp_ovf;
                        ss = (a > 7 ? a - 16 : a) + (b > 7 ? b - 16 : b) + ci;
                        exp_ovf = (ss > 7) || (ss < -8);
                        n_chk++;
                        if (bus.Ovf !== exp_ovf) begin
                            n_fail++;
                            $display("FAIL exh_ovf a=%0d b=%0d cin=%0d got %b exp %b", a, b, ci, bus.Ovf, exp_ovf);
                        end
                    end
`endif
                end
            end
        end
    endtask

    initial begin
        bus.A = '0;
        bus.B = '0;
        bus.Cin = 1'b0;
        bus.in_valid = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_signed();
        test_carry();
        test_overflow();
        test_reset_midstream();
        test_back_to_back();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
